// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, hold-while-requested
// semantics and an optional maximum-hold timeout that forces rotation.
module rr_grant_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int MAXHOLD = 16,
  parameter int CNTW    = 5
) (
  input  logic           C,
  input  logic           R,
  input  logic           CE,
  input  logic [N-1:0]   REQ,
  output logic [N-1:0]   GNT,
  output logic [IDW-1:0] GNT_ID,
  output logic           BUSY,
  output logic           ROT
);

  if (N < 2 || N > 8 || N > (1 << IDW)) begin : g_bad_n
    $error("rr_grant_arbiter: N must be 2..8 and fit in IDW bits");
  end
  if (MAXHOLD < 0 || MAXHOLD >= (1 << CNTW)) begin : g_bad_maxhold
    $error("rr_grant_arbiter: MAXHOLD must fit in CNTW bits");
  end

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state_r, state_s;
  logic [IDW-1:0]  ptr_r, ptr_s, id_s, start_s, win_s;
  logic [CNTW-1:0] cnt_r, cnt_s;
  logic [N-1:0]    cand_s, shifted_s;
  logic            busy_s, rot_s, found_s, held_s, timeout_s, excl_s;
  int              idx_s;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    if (i == IDW'(N - 1)) begin
      return {IDW{1'b0}};
    end else begin
      return i + IDW'(1);
    end
  endfunction

  assign held_s    = |(REQ & GNT);
  assign timeout_s = (MAXHOLD > 0) && (cnt_r == CNTW'(MAXHOLD - 1));
  // In GRANT the current holder is masked out; on release its request is low anyway.
  assign excl_s    = (state_r == GRANT);
  assign start_s   = (state_r == IDLE) ? ptr_r : next_idx(GNT_ID);
  assign cand_s    = REQ & ~(excl_s ? GNT : {N{1'b0}});

  // Circular first-one search starting at start_s.
  always_comb begin
    found_s   = 1'b0;
    win_s     = {IDW{1'b0}};
    idx_s     = 0;
    shifted_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      idx_s     = (int'(start_s) + i) % N;
      shifted_s = cand_s >> idx_s;
      if (!found_s && shifted_s[0]) begin
        found_s = 1'b1;
        win_s   = IDW'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state decision for grant, pointer, hold counter and rotation pulse.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    cnt_s   = cnt_r;
    id_s    = GNT_ID;
    busy_s  = BUSY;
    rot_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s = GRANT;
          id_s    = win_s;
          busy_s  = 1'b1;
          cnt_s   = {CNTW{1'b0}};
        end else begin
          busy_s  = 1'b0;
        end
      end
      GRANT: begin
        if (!held_s) begin
          ptr_s = next_idx(GNT_ID);
          cnt_s = {CNTW{1'b0}};
          if (found_s) begin
            id_s    = win_s;
          end else begin
            state_s = IDLE;
            busy_s  = 1'b0;
          end
        end else if (timeout_s) begin
          cnt_s = {CNTW{1'b0}};
          if (found_s) begin
            id_s  = win_s;
            ptr_s = next_idx(GNT_ID);
            rot_s = 1'b1;
          end else begin
            id_s  = GNT_ID;
          end
        end else begin
          cnt_s = (cnt_r == {CNTW{1'b1}}) ? cnt_r : cnt_r + CNTW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        cnt_s   = {CNTW{1'b0}};
      end
    endcase
  end

  // State and registered outputs; reset wins over clock enable.
  always_ff @(posedge C) begin
    if (R) begin
      state_r <= IDLE;
      ptr_r   <= {IDW{1'b0}};
      cnt_r   <= {CNTW{1'b0}};
      GNT     <= {N{1'b0}};
      GNT_ID  <= {IDW{1'b0}};
      BUSY    <= 1'b0;
      ROT     <= 1'b0;
    end else if (CE) begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      cnt_r   <= cnt_s;
      GNT     <= busy_s ? ({{(N-1){1'b0}}, 1'b1} << id_s) : {N{1'b0}};
      GNT_ID  <= id_s;
      BUSY    <= busy_s;
      ROT     <= rot_s;
    end
  end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that shares a single downstream resource (one gated output path) among N requesters.
- Registered one-hot grant with hold-while-requested semantics and an optional maximum-hold timeout that forces rotation.
- Sits between requester logic and the gate-level output mux/enable primitives; drives their select/enable inputs.
- Idle detect is the NOR of all requests, i.e. all-inverted-input AND across REQ.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, width of GNT_ID; 2**IDW >= N.
- MAXHOLD, 16, max consecutive grant cycles before forced rotation; 0 disables the timeout.
- CNTW, 5, hold counter width; MAXHOLD < 2**CNTW.

Ports:
- C  input  1  clock; all state updates on the rising edge.
- R  input  1  synchronous reset, active-high.
- CE  input  1  clock enable; low freezes all state and outputs.
- REQ  input  N  request vector, bit i = requester i.
- GNT  output  N  registered one-hot grant (all zero when idle).
- GNT_ID  output  IDW  binary index of the granted requester; holds its last value when idle.
- BUSY  output  1  high while any grant is active (OR of GNT).
- ROT  output  1  one-cycle pulse on a timeout-forced rotation.

Behaviour:
- Reset: R high at the edge sets GNT=0, GNT_ID=0, BUSY=0, ROT=0, priority pointer PTR=0, hold counter CNT=0, state IDLE.
  - R overrides CE.
  - R asserted mid-grant drops GNT on the next edge, with no handoff.
- CE=0: no state or output change. ROT is a registered pulse and also holds.
- Winner search from start index S: the lowest index k in S, S+1, ..., N-1, 0, ..., S-1 (mod N) with REQ[k]=1.
- IDLE state:
  - If |REQ, grant the winner from S=PTR on the next edge.
  - Set GNT=onehot(k), GNT_ID=k, CNT=0, go to GRANT.
  - Latency is 1 cycle from the REQ sample to GNT.
- GRANT state (granted index g):
  - Release (REQ[g]=0):
    - PTR becomes (g+1) mod N.
    - If another request is pending, grant the winner from S=g+1 on the same edge (no bubble cycle). CNT=0.
    - Otherwise GNT=0 and go to IDLE.
  - Hold (REQ[g]=1, and MAXHOLD=0 or CNT<MAXHOLD-1): keep g and increment CNT (saturating).
  - Timeout (REQ[g]=1, MAXHOLD>0, CNT=MAXHOLD-1):
    - If any REQ[j]=1 with j!=g: grant the winner from S=g+1 while excluding g, set PTR=(g+1) mod N, CNT=0, ROT=1 for one cycle.
    - Otherwise keep g, set CNT=0, ROT=0.
- GNT is always zero or one-hot. GNT_ID always matches GNT when BUSY=1.
- The granted requester gets at most MAXHOLD consecutive cycles while others wait.
- Requests arriving during GRANT are not acted on until release or timeout. No preemption otherwise.
- Simultaneous release and new requests: the handoff decision uses the REQ value sampled on that edge.
- REQ bits at index >= N do not exist. N must not exceed 2**IDW (elaboration check).

Test Plan:
- Reset/idle: R=1 for 2 cycles with REQ=4'b1111, then R=0 -> during reset GNT=0, BUSY=0; first edge after reset gives GNT=4'b0001, GNT_ID=0.
- Round-robin fairness: REQ=4'b1111 held, each holder drops its request for 1 cycle after 3 granted cycles -> grant order 0,1,2,3,0, no idle cycle between grants.
- Hold and release to idle: REQ=4'b0100 for 10 cycles, then 0 -> GNT=4'b0100 for 10 cycles, GNT=0 the cycle after REQ falls, BUSY follows.
- Timeout: MAXHOLD=4, REQ[1] held high, REQ[3] asserted at cycle 2 -> GNT=4'b0010 for 4 cycles, then GNT=4'b1000 with ROT=1 for exactly one cycle.
- Lone timeout: MAXHOLD=4, only REQ[2] high for 12 cycles -> GNT=4'b0100 throughout, ROT never asserted.
- CE/reset mid-grant: while GNT=4'b0010, CE=0 for 3 cycles with REQ changing -> outputs frozen; then R=1 -> GNT=0, GNT_ID=0, and the next grant searches from index 0.
